// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, datapath
// select codes and the opcode/funct constants of the supported subset.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_JAL = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic SRC_RD2 = 1'b0;
  localparam logic SRC_IMM = 1'b1;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  // One-hot instruction class; exactly one field is set for any Op/Funct.
  typedef struct packed {
    logic is_add;
    logic is_sub;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_jal;
    logic is_nop;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational classifier turning Op/Funct into a one-hot instruction class.
// Anything outside the supported subset is reported as a nop.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   Op,
  input  logic [5:0]   Funct,
  output instr_class_t cls
);

  // Match the opcode first, then the funct field for R-type encodings.
  always_comb begin
    cls = '0;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          FUNCT_ADD: cls.is_add = 1'b1;
          FUNCT_SUB: cls.is_sub = 1'b1;
          FUNCT_JR:  cls.is_jr  = 1'b1;
          default:   cls.is_nop = 1'b1;
        endcase
      end
      OP_ORI:  cls.is_ori = 1'b1;
      OP_LUI:  cls.is_lui = 1'b1;
      OP_LW:   cls.is_lw  = 1'b1;
      OP_SW:   cls.is_sw  = 1'b1;
      OP_BEQ:  cls.is_beq = 1'b1;
      OP_JAL:  cls.is_jal = 1'b1;
      default: cls.is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencer producing the
// datapath strobes and selects, plus a retired-instruction counter.
// Optional feature: define MC_CTRL_MEM_WAIT_EN to add the mem_ready input and
// let MEM stall until data memory is ready.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [3:0]       ALUOp,
  output logic [1:0]       EXTOp,
  output logic [2:0]       NPCOp,
  output logic             ALUSrc_Sel,
  output logic [1:0]       RegDst_Sel,
  output logic [1:0]       GRFWD_Sel,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCnt
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  instr_class_t     cls;
  logic             mem_go;

  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic [3:0] alu_op;
  logic [1:0] ext_op;
  logic [2:0] npc_op;
  logic       alu_src;
  logic [1:0] reg_dst;
  logic [1:0] grf_wd;

  mc_decode u_decode (
    .Op   (Op),
    .Funct(Funct),
    .cls  (cls)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // Next state and all control outputs from the current state and class.
  always_comb begin
    state_d   = ST_FETCH;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_op    = ALU_ADD;
    ext_op    = EXT_ZERO;
    npc_op    = NPC_PC4;
    alu_src   = SRC_RD2;
    reg_dst   = DST_RT;
    grf_wd    = WD_ALU;
    case (state_q)
      ST_FETCH: begin
        ir_write = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls.is_jr) begin
          pc_write = 1'b1;
          npc_op   = NPC_JR;
        end else if (cls.is_nop) begin
          pc_write = 1'b1;
        end else if (cls.is_jal) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        if (cls.is_sub) begin
          alu_op = ALU_SUB;
        end
        if (cls.is_ori) begin
          alu_op  = ALU_OR;
          alu_src = SRC_IMM;
        end
        if (cls.is_lui) begin
          alu_op  = ALU_LUI;
          alu_src = SRC_IMM;
        end
        if (cls.is_lw || cls.is_sw) begin
          ext_op  = EXT_SIGN;
          alu_src = SRC_IMM;
          state_d = ST_MEM;
        end
        if (cls.is_beq) begin
          alu_op   = ALU_SUB;
          ext_op   = EXT_SIGN;
          pc_write = 1'b1;
          npc_op   = NPC_BEQ;
          state_d  = ST_FETCH;
        end
      end
      ST_MEM: begin
`ifdef MC_CTRL_MEM_WAIT_EN
        alu_op  = ALU_ADD;
        ext_op  = EXT_SIGN;
        alu_src = SRC_IMM;
`endif
        if (!mem_go) begin
          state_d = ST_MEM;
        end else if (cls.is_sw) begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (cls.is_add || cls.is_sub) begin
          reg_dst = DST_RD;
        end
        if (cls.is_lw) begin
          grf_wd = WD_DM;
        end
        if (cls.is_jal) begin
          reg_dst = DST_R31;
          grf_wd  = WD_PC4;
          npc_op  = NPC_JAL;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State register and retired-instruction counter, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_write) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign IRWrite    = ir_write & reset;
  assign PCWrite    = pc_write & reset;
  assign MemWrite   = mem_write & reset;
  assign RegWrite   = reg_write & reset;
  assign ALUOp      = alu_op;
  assign EXTOp      = ext_op;
  assign NPCOp      = npc_op;
  assign ALUSrc_Sel = alu_src;
  assign RegDst_Sel = reg_dst;
  assign GRFWD_Sel  = grf_wd;
  assign State      = state_q;
  assign InstrCnt   = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl with a 4-bit instruction counter.
// Each instruction pushes its expected profile into a scoreboard queue; the
// profile is popped and compared once the instruction has retired.
module tb_mc_ctrl;

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam int WAIT_LAT = 3;
`else
  localparam int WAIT_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, PCWrite, MemWrite, RegWrite, ALUSrc_Sel;
  logic [3:0] ALUOp;
  logic [1:0] EXTOp, RegDst_Sel, GRFWD_Sel;
  logic [2:0] NPCOp, State;
  logic [3:0] InstrCnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] model_cnt = 4'd0;

  typedef struct {
    string       tag;
    int          lat;
    logic [23:0] seq;
    logic [2:0]  npc;
    int          rw;
    int          mw;
    logic [1:0]  rd;
    logic [1:0]  gw;
    logic [3:0]  alu;
    logic [1:0]  ext;
    logic        src;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb_q[$];

  mc_ctrl #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .ALUOp     (ALUOp),
    .EXTOp     (EXTOp),
    .NPCOp     (NPCOp),
    .ALUSrc_Sel(ALUSrc_Sel),
    .RegDst_Sel(RegDst_Sel),
    .GRFWD_Sel (GRFWD_Sel),
    .State     (State),
    .InstrCnt  (InstrCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] sq(input logic [23:0] s, input logic [2:0] st);
    return {s[20:0], st};
  endfunction

  // Reference profile of one instruction, written from the instruction table.
  function automatic exp_t expect_for(input logic [5:0] op, input logic [5:0] fn,
                                      input int w, input string tag);
    exp_t e;
    e.tag = tag; e.npc = 3'd0; e.rw = 0; e.mw = 0; e.rd = 2'd0; e.gw = 2'd0;
    e.alu = 4'd0; e.ext = 2'd0; e.src = 1'b0;
    e.seq = sq(sq(24'd0, 3'd0), 3'd1);
    e.lat = 2;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
      e.lat = 4; e.seq = sq(sq(e.seq, 3'd2), 3'd4); e.rw = 1; e.rd = 2'd1;
      e.alu = (fn == 6'h22) ? 4'd1 : 4'd0;
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.npc = 3'd3;
    end else if (op == 6'h0D || op == 6'h0F) begin
      e.lat = 4; e.seq = sq(sq(e.seq, 3'd2), 3'd4); e.rw = 1; e.src = 1'b1;
      e.alu = (op == 6'h0D) ? 4'd2 : 4'd3;
    end else if (op == 6'h23 || op == 6'h2B) begin
      e.seq = sq(e.seq, 3'd2);
      for (int i = 0; i <= w; i++) e.seq = sq(e.seq, 3'd3);
      e.ext = 2'd1; e.src = 1'b1;
      if (op == 6'h23) begin
        e.lat = 5 + w; e.seq = sq(e.seq, 3'd4); e.rw = 1; e.gw = 2'd1;
      end else begin
        e.lat = 4 + w; e.mw = 1;
      end
    end else if (op == 6'h04) begin
      e.lat = 3; e.seq = sq(e.seq, 3'd2); e.npc = 3'd1; e.alu = 4'd1; e.ext = 2'd1;
    end else if (op == 6'h03) begin
      e.lat = 3; e.seq = sq(e.seq, 3'd4); e.npc = 3'd2; e.rw = 1;
      e.rd = 2'd2; e.gw = 2'd2;
    end
    e.cnt = model_cnt + 4'd1;
    return e;
  endfunction

  // Run one instruction from FETCH back to FETCH and score what was seen.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input int w, input string tag);
    exp_t e;
    int n = 0, waits = 0, irw = 0, pcw = 0, mw = 0, rw = 0, sel_out = 0;
    logic [23:0] seq = 24'd0;
    logic [2:0] npc = 3'd7;
    logic [1:0] rd = 2'd3, gw = 2'd3, ext = 2'd0;
    logic [3:0] alu = 4'd0;
    logic src = 1'b0;
    sb_q.push_back(expect_for(op, fn, w, tag));
    model_cnt = model_cnt + 4'd1;
    Op = op; Funct = fn;
    while (n < 20) begin
      if (State == 3'd3 && waits < w) begin
        mem_ready = 1'b0; waits++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (n > 0 && State == 3'd0) break;
      seq = sq(seq, State);
      if (IRWrite) irw++;
      if (MemWrite) mw++;
      if (RegWrite) rw++;
      if (State != 3'd4 && (RegDst_Sel != 2'd0 || GRFWD_Sel != 2'd0)) sel_out++;
      if (State == 3'd2) begin
        alu = ALUOp; ext = EXTOp; src = ALUSrc_Sel;
      end
      if (PCWrite) begin
        pcw++; npc = NPCOp; rd = RegDst_Sel; gw = GRFWD_Sel;
      end
      n++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    e = sb_q.pop_front();
    checkOutput({e.tag, "/timeout"}, 32'(n >= 20), 32'd0);
    checkOutput({e.tag, "/latency"}, 32'(n), 32'(e.lat));
    checkOutput({e.tag, "/states"}, 32'(seq), 32'(e.seq));
    checkOutput({e.tag, "/irwrite_cycles"}, 32'(irw), 32'd1);
    checkOutput({e.tag, "/pcwrite_cycles"}, 32'(pcw), 32'd1);
    checkOutput({e.tag, "/memwrite_cycles"}, 32'(mw), 32'(e.mw));
    checkOutput({e.tag, "/regwrite_cycles"}, 32'(rw), 32'(e.rw));
    checkOutput({e.tag, "/npcop"}, 32'(npc), 32'(e.npc));
    checkOutput({e.tag, "/regdst"}, 32'(rd), 32'(e.rd));
    checkOutput({e.tag, "/grfwd"}, 32'(gw), 32'(e.gw));
    checkOutput({e.tag, "/sel_outside_wb"}, 32'(sel_out), 32'd0);
    checkOutput({e.tag, "/aluop"}, 32'(alu), 32'(e.alu));
    checkOutput({e.tag, "/extop"}, 32'(ext), 32'(e.ext));
    checkOutput({e.tag, "/alusrc"}, 32'(src), 32'(e.src));
    checkOutput({e.tag, "/instrcnt"}, 32'(InstrCnt), 32'(e.cnt));
  endtask

  logic [5:0] tbl_op [10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h03, 6'h3F};
  logic [5:0] tbl_fn [10] = '{6'h20, 6'h22, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    int k;
    int mw_rst, rw_rst;
    reset = 1'b0; Op = 6'h3F; Funct = 6'h00; mem_ready = 1'b1;
    #3;
    checkOutput("reset/state", 32'(State), 32'd0);
    checkOutput("reset/instrcnt", 32'(InstrCnt), 32'd0);
    checkOutput("reset/irwrite", 32'(IRWrite), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(6'h3F, 6'h00, 0, "nop_wrap");
      if (i == 14) checkOutput("wrap/15", 32'(InstrCnt), 32'd15);
      if (i == 15) checkOutput("wrap/0", 32'(InstrCnt), 32'd0);
      if (i == 16) checkOutput("wrap/1", 32'(InstrCnt), 32'd1);
    end

    applyStimulus(6'h00, 6'h20, 0, "add");
    applyStimulus(6'h00, 6'h22, 0, "sub");
    applyStimulus(6'h0D, 6'h00, 0, "ori");
    applyStimulus(6'h0F, 6'h00, 0, "lui");
    applyStimulus(6'h23, 6'h00, WAIT_LAT, "lw");
    applyStimulus(6'h2B, 6'h00, 0, "sw");
    applyStimulus(6'h2B, 6'h00, (WAIT_LAT > 0) ? 2 : 0, "sw_wait");
    applyStimulus(6'h04, 6'h00, 0, "beq");
    applyStimulus(6'h03, 6'h00, 0, "jal");
    applyStimulus(6'h00, 6'h08, 0, "jr");
    applyStimulus(6'h3F, 6'h00, 0, "nop3f");
    applyStimulus(6'h00, 6'h3F, 0, "nop_funct");

    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 9);
      applyStimulus(tbl_op[k], tbl_fn[k], (WAIT_LAT > 0) ? $urandom_range(0, 2) : 0, "rand");
    end

    // Reset while an lw sits in EXEC.
    Op = 6'h23; Funct = 6'h00;
    for (int i = 0; i < 10 && State != 3'd2; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("rst_lw/in_exec", 32'(State), 32'd2);
    reset = 1'b0;
    #1;
    checkOutput("rst_lw/state", 32'(State), 32'd0);
    checkOutput("rst_lw/strobes", 32'({IRWrite, PCWrite, MemWrite, RegWrite}), 32'd0);
    checkOutput("rst_lw/instrcnt", 32'(InstrCnt), 32'd0);
    mw_rst = 0; rw_rst = 0;
    repeat (2) begin
      @(negedge clk); #1;
      if (MemWrite) mw_rst++;
      if (RegWrite) rw_rst++;
    end
    checkOutput("rst_lw/no_mem_reg_write", 32'(mw_rst + rw_rst), 32'd0);
    model_cnt = 4'd0;
    Op = 6'h3F;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(6'h3F, 6'h00, 0, "post_reset_nop");
    applyStimulus(6'h00, 6'h20, 0, "post_reset_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Op, input, 6: opcode field from the instruction register.
REQ-005 SHALL have port Funct, input, 6: funct field from the instruction register.
REQ-006 SHALL have port mem_ready, input, 1: data-memory ready; present only when MC_CTRL_MEM_WAIT_EN is defined.
REQ-007 SHALL have ports IRWrite, PCWrite, MemWrite and RegWrite, each output, 1: write strobes for the instruction register, PC, DM and GRF.
REQ-008 SHALL have port ALUOp, output, 4: ADD=0, SUB=1, OR=2, LUI=3.
REQ-009 SHALL have port EXTOp, output, 2: ZERO=0, SIGN=1.
REQ-010 SHALL have port NPCOp, output, 3: PC4=0, BEQ=1, JAL=2, JR=3.
REQ-011 SHALL have port ALUSrc_Sel, output, 1: 0 selects RD2, 1 selects EXTImm.
REQ-012 SHALL have port RegDst_Sel, output, 2: 0 selects rt, 1 selects rd, 2 selects register 31.
REQ-013 SHALL have port GRFWD_Sel, output, 2: 0 selects the ALU result, 1 selects DM data, 2 selects PC+4.
REQ-014 SHALL have port State, output, 3: current FSM state, for debug.
REQ-015 SHALL have port InstrCnt, output, CNT_W: count of retired instructions.

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3 and WB=4; encodings 5-7 SHALL return to FETCH on the next edge.
REQ-017 SHALL make all outputs combinational functions of State, Op and Funct only; Op and Funct are stable from DECODE to the end of the instruction.
REQ-018 SHALL recognise: add (000000/100000), sub (000000/100010), jr (000000/001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100) and jal (000011); every other encoding is treated as nop.
REQ-019 SHALL assert IRWrite only in FETCH, and FETCH SHALL always go to DECODE.
REQ-020 DECODE SHALL go to FETCH with PCWrite=1 for jr (NPCOp=JR) and for nop (NPCOp=PC4).
REQ-021 DECODE SHALL go to WB for jal, and to EXEC for all other recognised instructions.
REQ-022 EXEC SHALL drive: add ALUOp=ADD, ALUSrc_Sel=0; sub ALUOp=SUB, ALUSrc_Sel=0; ori ALUOp=OR, EXTOp=ZERO, ALUSrc_Sel=1; lui ALUOp=LUI, ALUSrc_Sel=1; lw/sw ALUOp=ADD, EXTOp=SIGN, ALUSrc_Sel=1; beq ALUOp=SUB, ALUSrc_Sel=0, EXTOp=SIGN.
REQ-023 EXEC SHALL go to MEM for lw/sw, and to WB for add/sub/ori/lui.
REQ-024 EXEC SHALL go to FETCH for beq with PCWrite=1 and NPCOp=BEQ; the NPC resolves taken/not-taken from Zero.
REQ-025 In MEM, sw SHALL assert MemWrite=1 and PCWrite=1 (NPCOp=PC4) and go to FETCH; lw SHALL go to WB.
REQ-026 WB SHALL assert RegWrite=1 and PCWrite=1 and go to FETCH.
REQ-027 WB SHALL select: add/sub RegDst_Sel=1, GRFWD_Sel=0; ori/lui RegDst_Sel=0, GRFWD_Sel=0; lw RegDst_Sel=0, GRFWD_Sel=1; jal RegDst_Sel=2, GRFWD_Sel=2, NPCOp=JAL; all others NPCOp=PC4.
REQ-028 SHALL hold to exact latencies in cycles: jr/nop 2, beq/jal 3, add/sub/ori/lui/sw 4, lw 5 (MEM_WAIT off, or mem_ready already high).
REQ-029 SHALL assert PCWrite exactly once per instruction, in its final state; InstrCnt SHALL increment on that edge and wrap from all-ones to 0.
REQ-030 In any state, outputs not specified above SHALL be 0.

Reset
REQ-031 reset low SHALL immediately force State=FETCH and InstrCnt=0, aborting any instruction in progress.
REQ-032 While reset is low, IRWrite, PCWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-033 The first FETCH after reset deasserts SHALL occur on the next rising edge of clk.

Configuration
REQ-034 With MC_CTRL_MEM_WAIT_EN defined, MEM SHALL hold while mem_ready=0, with MemWrite/PCWrite=0 and the EXEC address selects held.
REQ-035 With MC_CTRL_MEM_WAIT_EN defined, the MEM exit and strobes of REQ-025 SHALL occur only in the cycle mem_ready=1, so MemWrite is a single pulse.
REQ-036 With MC_CTRL_MEM_WAIT_EN undefined, the mem_ready port SHALL be absent and MEM SHALL last exactly 1 cycle.

Structure
REQ-037 SHALL place the state encodings; the ALUOp, EXTOp, NPCOp, RegDst and GRFWD codes; and the opcode/funct constants in shared package mc_ctrl_pkg.
REQ-038 SHALL implement the instruction classification of Op/Funct as combinational sub-module mc_decode, outputting a one-hot instruction class.

Verification
REQ-039 Bench SHALL drive add (Op=0, Funct=0x20) and check the state sequence 0,1,2,4,0, RegWrite=1 and RegDst_Sel=1 only in WB, and InstrCnt 0 to 1.
REQ-040 Bench SHALL drive lw with MEM_WAIT on, mem_ready low 3 cycles: 8-cycle latency, GRFWD_Sel=1 in WB, PCWrite high in exactly 1 cycle.
REQ-041 Bench SHALL drive sw: MemWrite high for exactly 1 cycle (in MEM), RegWrite never asserted, 4-cycle latency.
REQ-042 Bench SHALL drive beq, jal, jr and Op=0x3F: latencies 3, 3, 2 and 2; NPCOp=1, 2, 3 and 0 in the PCWrite cycle; jal RegDst_Sel=2, GRFWD_Sel=2.
REQ-043 Bench SHALL assert reset low mid-EXEC of lw: State=0 and all strobes 0 immediately, InstrCnt=0, and no MemWrite or RegWrite afterwards for that lw.
REQ-044 Bench SHALL run with CNT_W=4 for 17 nops: InstrCnt reads 15, then 0, then 1.
